// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between instruction fetch (IF) and
// load/store (DM). Only one access is in flight at a time. DM normally wins,
// but a burst counter limits DM to MAX_DM_BURST back-to-back grants while a
// fetch is waiting, so fetch is never starved.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr/if_flush       fetch request, address, response cancel
//   if_gnt/if_valid/if_rdata      fetch accept, response pulse, response data
//   dm_req/dm_we/dm_addr/dm_wdata load/store request (dm_we==0 is a load)
//   dm_gnt/dm_valid/dm_rdata      data accept, response/ack pulse, load data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata           memory macro interface
//   busy                          an access is in flight
//
// Timing: a grant in cycle T gives the response pulse in T+MEM_LAT and the
// next grant no earlier than T+MEM_LAT+1.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_DM_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [XLEN-1:0]   dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [XLEN-1:0]   dm_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              busy
);

    localparam int LAT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int BURST_W = $clog2(MAX_DM_BURST + 1);

    localparam logic [LAT_W-1:0]   LAT_INIT  = LAT_W'(MEM_LAT - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DM_BURST);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               flush_q, flush_d;
    logic               dm_wins;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            lat_q   <= '0;
            burst_q <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            burst_q <= burst_d;
            flush_q <= flush_d;
        end
    end

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        burst_d   = burst_q;
        flush_d   = flush_q;
        dm_wins   = 1'b0;
        if_gnt    = 1'b0;
        if_valid  = 1'b0;
        if_rdata  = '0;
        dm_gnt    = 1'b0;
        dm_valid  = 1'b0;
        dm_rdata  = '0;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q == WAIT);

        unique case (state_q)
            IDLE: begin
                // DM has priority until it has taken MAX_DM_BURST grants in a
                // row while a fetch was waiting.
                dm_wins = dm_req && !(if_req && (burst_q == BURST_MAX));
                if (dm_wins) begin
                    dm_gnt    = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = dm_we;
                    mem_addr  = dm_addr;
                    mem_wdata = dm_wdata;
                    state_d   = WAIT;
                    lat_d     = LAT_INIT;
                    owner_d   = OWN_DM;
                    flush_d   = 1'b0;
                    if (!if_req)
                        burst_d = '0;
                    else if (burst_q != BURST_MAX)
                        burst_d = burst_q + BURST_W'(1);
                end else if (if_req) begin
                    if_gnt   = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = if_addr;
                    state_d  = WAIT;
                    lat_d    = LAT_INIT;
                    owner_d  = OWN_IF;
                    burst_d  = '0;
                    // A flush in the grant cycle already cancels this fetch.
                    flush_d  = if_flush;
                end
            end

            WAIT: begin
                if (owner_q == OWN_IF && if_flush)
                    flush_d = 1'b1;
                if (lat_q == '0) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    if (owner_q == OWN_DM) begin
                        dm_valid = 1'b1;
                        dm_rdata = mem_rdata;
                    end else if (!(flush_q || if_flush)) begin
                        if_valid = 1'b1;
                        if_rdata = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        // While reset is held nothing may be granted or reported, including a
        // response that would otherwise complete in this cycle.
        if (rst) begin
            if_gnt    = 1'b0;
            if_valid  = 1'b0;
            if_rdata  = '0;
            dm_gnt    = 1'b0;
            dm_valid  = 1'b0;
            dm_rdata  = '0;
            mem_en    = 1'b0;
            mem_we    = '0;
            mem_addr  = '0;
            mem_wdata = '0;
            busy      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiters are exercised side by side: u0 with MEM_LAT=1 and u1 with
// MEM_LAT=3, both with MAX_DM_BURST=4. Each has its own small memory. A
// transaction-level reference model (next-free cycle, response cycle, DM
// streak count) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int MAX_BURST = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RAND  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_IFSEQ = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst, if_req, if_flush, dm_req;
    logic [1:0][31:0]  if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [1:0][3:0]   dm_we;
    wire  [1:0]        if_gnt, if_valid, dm_gnt, dm_valid, mem_en, busy;
    wire  [1:0][31:0]  if_rdata, dm_rdata, mem_addr, mem_wdata;
    wire  [1:0][3:0]   mem_we;

    mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .MEM_LAT(1), .MAX_DM_BURST(MAX_BURST)) u0 (
        .clk(clk), .rst(rst[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_flush(if_flush[0]),
        .if_gnt(if_gnt[0]), .if_valid(if_valid[0]), .if_rdata(if_rdata[0]),
        .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
        .dm_gnt(dm_gnt[0]), .dm_valid(dm_valid[0]), .dm_rdata(dm_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .MEM_LAT(3), .MAX_DM_BURST(MAX_BURST)) u1 (
        .clk(clk), .rst(rst[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_flush(if_flush[1]),
        .if_gnt(if_gnt[1]), .if_valid(if_valid[1]), .if_rdata(if_rdata[1]),
        .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
        .dm_gnt(dm_gnt[1]), .dm_valid(dm_valid[1]), .dm_rdata(dm_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
    );

    // ---------------- memories (environment, one per DUT) ----------------
    logic [31:0] mem [2][256];
    logic [7:0]  raddr [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i]) begin
                if (mem_we[i] != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_we[i][b]) mem[i][mem_addr[i][9:2]][8*b +: 8] <= mem_wdata[i][8*b +: 8];
                end else begin
                    raddr[i] <= mem_addr[i][9:2];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) mem_rdata[i] = mem[i][raddr[i]];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc;
    int          free_at [2];   // first cycle a new grant may be issued
    int          resp_at [2];   // cycle of the pending response
    bit          pend    [2];
    bit          resp_dm [2];
    bit          resp_ld [2];
    bit          flushed [2];
    logic [31:0] resp_data [2];
    int          streak  [2];   // DM grants in a row while a fetch waited
    bit          g_if [2];
    bit          g_dm [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic eval(input int i);
        bit    exp_ifv, exp_dmv, can, dmw, ifw, exp_busy;
        string u;
        u = $sformatf("u%0d.", i);
        g_if[i] = 1'b0;
        g_dm[i] = 1'b0;

        if (rst[i]) begin
            check({u, "rst_if_gnt"},    32'(if_gnt[i]),   32'd0);
            check({u, "rst_dm_gnt"},    32'(dm_gnt[i]),   32'd0);
            check({u, "rst_if_valid"},  32'(if_valid[i]), 32'd0);
            check({u, "rst_dm_valid"},  32'(dm_valid[i]), 32'd0);
            check({u, "rst_mem_en"},    32'(mem_en[i]),   32'd0);
            check({u, "rst_mem_we"},    32'(mem_we[i]),   32'd0);
            check({u, "rst_mem_addr"},  mem_addr[i],      32'd0);
            check({u, "rst_mem_wdata"}, mem_wdata[i],     32'd0);
            check({u, "rst_if_rdata"},  if_rdata[i],      32'd0);
            check({u, "rst_dm_rdata"},  dm_rdata[i],      32'd0);
            check({u, "rst_busy"},      32'(busy[i]),     32'd0);
            free_at[i] = cyc + 1;
            pend[i]    = 1'b0;
            streak[i]  = 0;
            return;
        end

        exp_busy = (cyc < free_at[i]);
        if (pend[i] && !resp_dm[i] && if_flush[i]) flushed[i] = 1'b1;
        exp_ifv = 1'b0;
        exp_dmv = 1'b0;
        if (pend[i] && cyc == resp_at[i]) begin
            if (resp_dm[i]) exp_dmv = 1'b1;
            else            exp_ifv = !flushed[i];
            pend[i] = 1'b0;
        end

        can = (cyc >= free_at[i]);
        dmw = can && dm_req[i] && !(if_req[i] && streak[i] >= MAX_BURST);
        ifw = can && !dmw && if_req[i];

        check({u, "if_gnt"},    32'(if_gnt[i]),            32'(ifw));
        check({u, "dm_gnt"},    32'(dm_gnt[i]),            32'(dmw));
        check({u, "gnt_excl"},  32'(if_gnt[i] & dm_gnt[i]), 32'd0);
        check({u, "mem_en"},    32'(mem_en[i]),            32'(dmw || ifw));
        check({u, "busy"},      32'(busy[i]),              32'(exp_busy));
        check({u, "if_valid"},  32'(if_valid[i]),          32'(exp_ifv));
        check({u, "dm_valid"},  32'(dm_valid[i]),          32'(exp_dmv));
        if (exp_ifv) check({u, "if_rdata"}, if_rdata[i], resp_data[i]);
        if (exp_dmv && resp_ld[i]) check({u, "dm_rdata"}, dm_rdata[i], resp_data[i]);

        if (dmw) begin
            check({u, "mem_addr_dm"},  mem_addr[i],       dm_addr[i]);
            check({u, "mem_we_dm"},    32'(mem_we[i]),    32'(dm_we[i]));
            check({u, "mem_wdata_dm"}, mem_wdata[i],      dm_wdata[i]);
            streak[i]    = if_req[i] ? ((streak[i] < MAX_BURST) ? streak[i] + 1 : MAX_BURST) : 0;
            resp_dm[i]   = 1'b1;
            resp_ld[i]   = (dm_we[i] == 4'b0000);
            resp_data[i] = mem[i][dm_addr[i][9:2]];
            flushed[i]   = 1'b0;
            g_dm[i]      = 1'b1;
        end else if (ifw) begin
            check({u, "mem_addr_if"}, mem_addr[i],    if_addr[i]);
            check({u, "mem_we_if"},   32'(mem_we[i]), 32'd0);
            streak[i]    = 0;
            resp_dm[i]   = 1'b0;
            resp_ld[i]   = 1'b1;
            resp_data[i] = mem[i][if_addr[i][9:2]];
            flushed[i]   = if_flush[i];
            g_if[i]      = 1'b1;
        end
        if (dmw || ifw) begin
            pend[i]    = 1'b1;
            resp_at[i] = cyc + lat_of(i);
            free_at[i] = cyc + lat_of(i) + 1;
        end
    endtask

    // ---------------- stimulus ----------------
    int          mode      [2];
    bit          rst_cmd   [2];
    bit          flush_cmd [2];
    logic [31:0] seq_addr  [2];
    bit          rec_on;
    string       hold_seq [$];

    task automatic gen(input int i);
        if (g_if[i]) if_req[i] = 1'b0;
        if (g_dm[i]) dm_req[i] = 1'b0;
        rst[i]      = rst_cmd[i];
        if_flush[i] = flush_cmd[i];
        case (mode[i])
            M_IDLE: begin
                if_req[i] = 1'b0;
                dm_req[i] = 1'b0;
            end
            M_RAND: begin
                if (!if_req[i] && ($urandom % 3 == 0)) begin
                    if_req[i]  = 1'b1;
                    if_addr[i] = 32'($urandom_range(0, 255)) << 2;
                end
                if (!dm_req[i] && ($urandom % 3 == 0)) begin
                    dm_req[i]   = 1'b1;
                    dm_we[i]    = ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                    dm_addr[i]  = 32'($urandom_range(0, 255)) << 2;
                    dm_wdata[i] = $urandom;
                end
                if_flush[i] = flush_cmd[i] || ($urandom % 8 == 0);
            end
            M_HOLD: begin
                if (!if_req[i]) begin
                    if_req[i]  = 1'b1;
                    if_addr[i] = 32'($urandom_range(0, 255)) << 2;
                end
                if (!dm_req[i]) begin
                    dm_req[i]   = 1'b1;
                    dm_we[i]    = 4'b0000;
                    dm_addr[i]  = 32'($urandom_range(0, 255)) << 2;
                    dm_wdata[i] = $urandom;
                end
            end
            default: begin // M_IFSEQ: fetch-only, sequential addresses
                dm_req[i] = 1'b0;
                if (!if_req[i]) begin
                    if_req[i]   = 1'b1;
                    if_addr[i]  = seq_addr[i];
                    seq_addr[i] = seq_addr[i] + 32'd4;
                end
            end
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) gen(i);
        #1;
        for (int i = 0; i < 2; i++) eval(i);
        if (rec_on && (if_gnt[0] || dm_gnt[0])) hold_seq.push_back(if_gnt[0] ? "I" : "D");
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        string pat;
        bool_t_dummy: begin end
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 256; k++) mem[i][k] = $urandom;
            raddr[i]     = 8'd0;
            mode[i]      = M_IDLE;
            rst_cmd[i]   = 1'b1;
            flush_cmd[i] = 1'b0;
            seq_addr[i]  = 32'h0;
            free_at[i]   = 0;
            resp_at[i]   = 0;
            pend[i]      = 1'b0;
            streak[i]    = 0;
            g_if[i]      = 1'b0;
            g_dm[i]      = 1'b0;
        end
        rst = 2'b11; if_req = '0; if_flush = '0; dm_req = '0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_we = '0;
        cyc = 0; rec_on = 1'b0;

        // Reset, then idle with no requests.
        steps(3);
        rst_cmd[0] = 1'b0; rst_cmd[1] = 1'b0;
        steps(3);

        // Fetch-only sequential stream on both latencies.
        mode[0] = M_IFSEQ; mode[1] = M_IFSEQ;
        steps(14);

        // Flush of an in-flight fetch on u1 (MEM_LAT=3), the cycle after grant.
        mode[0] = M_IDLE;
        begin
            int n = 0;
            while (!g_if[1] && n < 20) begin step(); n++; end
            check("u1.flush_grant_seen", 32'(g_if[1]), 32'd1);
            flush_cmd[1] = 1'b1;
            step();
            flush_cmd[1] = 1'b0;
            mode[1] = M_IDLE;
            steps(5);
        end

        // Both requests held on u0 from a fresh reset: 4 DM grants, then IF.
        rst_cmd[0] = 1'b1; step(); rst_cmd[0] = 1'b0;
        mode[0] = M_HOLD; rec_on = 1'b1;
        steps(24);
        rec_on = 1'b0;
        pat = "DDDDIDDDDI";
        check("hold_seq_len_ok", 32'(hold_seq.size() >= 10), 32'd1);
        for (int k = 0; k < 10 && k < hold_seq.size(); k++)
            check($sformatf("hold_seq[%0d]", k), 32'(hold_seq[k] == "I"), 32'(pat[k] == "I"));

        // Randomised traffic with occasional resets.
        mode[0] = M_RAND; mode[1] = M_RAND;
        for (int k = 0; k < 1500; k++) begin
            rst_cmd[0] = ($urandom % 101 == 0);
            rst_cmd[1] = ($urandom % 97 == 0);
            step();
        end
        rst_cmd[0] = 1'b0; rst_cmd[1] = 1'b0;

        // Reset while u1 waits on a DM access: no dm_valid afterwards.
        begin
            int n = 0;
            while (!(pend[1] && resp_dm[1] && cyc < resp_at[1] - 1) && n < 300) begin step(); n++; end
            check("u1.dm_wait_found", 32'(n < 300), 32'd1);
            mode[1] = M_IDLE;
            rst_cmd[1] = 1'b1; step(); rst_cmd[1] = 1'b0;
            steps(6);
        end

        mode[0] = M_IDLE; mode[1] = M_IDLE;
        steps(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
